// File: rtl/led_status_sched_if.sv
// Request/status bundle between the PLC status sources and the LED scheduler.
// master: status sources + LED pin consumer; slave: the scheduler.
interface led_status_sched_if;
  logic [2:0] req_valid;
  logic [8:0] req_color;
  logic [2:0] req_blink;
  logic [2:0] grant;
  logic       LED_R;
  logic       LED_G;
  logic       LED_B;

  modport master (
    output req_valid, req_color, req_blink,
    input  grant, LED_R, LED_G, LED_B
  );

  modport slave (
    input  req_valid, req_color, req_blink,
    output grant, LED_R, LED_G, LED_B
  );
endinterface

// File: rtl/led_status_sched.sv
// Priority scheduler sharing one active-low RGB LED among three requesters
// (bit 0 = highest priority). Enforces a minimum display time per grant,
// a dark gap between owners, and solid/blink colour from a prescaled tick.
// Optional feature: define LED_STATUS_SCHED_PREEMPT_EN to let a higher-priority
// request cut the current grant short without waiting for the minimum hold.
module led_status_sched #(
  parameter int unsigned CLK_HZ         = 12000000,
  parameter int unsigned TICK_HZ        = 10,
  parameter int unsigned MIN_HOLD_TICKS = 5,
  parameter int unsigned BLINK_TICKS    = 3
) (
  input logic              clk,
  input logic              rst,
  led_status_sched_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned TW  = $clog2(DIV);
  localparam int unsigned HW  = $clog2(MIN_HOLD_TICKS + 1);
  localparam int unsigned BW  = $clog2(BLINK_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase_on, phase_n;
  logic [2:0]    color_q, color_n;
  logic          blink_q, blink_n;
  logic [2:0]    grant_q, grant_n;
  logic [2:0]    led_q, led_n;

  logic [2:0]    pick;
  logic          owner_valid;
  logic          higher_valid;
  logic          hold_met;
  logic          release_now;
  logic          load;

  // One-hot of the highest-priority (lowest index) set bit.
  function automatic logic [2:0] first_one(input logic [2:0] v);
    logic [2:0] r;
    r = '0;
    if (v[0])      r = 3'b001;
    else if (v[1]) r = 3'b010;
    else if (v[2]) r = 3'b100;
    return r;
  endfunction

  // Free-running prescaler; tick is high during the last count before wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  assign pick         = first_one(bus.req_valid);
  assign owner_valid  = |(bus.req_valid & grant_q);
  // Bits below the one-hot owner are the higher-priority requesters.
  assign higher_valid = |(bus.req_valid & (grant_q - 3'd1));
  assign hold_met     = (hold_cnt == HOLD_MAX);

`ifdef LED_STATUS_SCHED_PREEMPT_EN
  assign release_now = higher_valid || (hold_met && !owner_valid);
`else
  assign release_now = hold_met && (higher_valid || !owner_valid);
`endif

  // Next-state, grant latching, hold/blink counting and next LED levels.
  always_comb begin
    state_n     = state;
    grant_n     = grant_q;
    color_n     = color_q;
    blink_n     = blink_q;
    phase_n     = phase_on;
    hold_n      = hold_cnt;
    blink_cnt_n = blink_cnt;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (|bus.req_valid) load = 1'b1;
      end
      ACTIVE: begin
        // Release takes precedence over a blink toggle on the same edge.
        if (release_now) begin
          state_n = (|bus.req_valid) ? GAP : IDLE;
          grant_n = '0;
        end else if (tick) begin
          if (!hold_met) hold_n = hold_cnt + 1'b1;
          if (blink_q) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt_n = '0;
              phase_n     = ~phase_on;
            end else begin
              blink_cnt_n = blink_cnt + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (|bus.req_valid) load = 1'b1;
          else                state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase

    if (load) begin
      state_n     = ACTIVE;
      grant_n     = pick;
      color_n     = ({3{pick[0]}} & bus.req_color[2:0])
                  | ({3{pick[1]}} & bus.req_color[5:3])
                  | ({3{pick[2]}} & bus.req_color[8:6]);
      blink_n     = |(pick & bus.req_blink);
      hold_n      = '0;
      blink_cnt_n = '0;
      phase_n     = 1'b1;
    end

    led_n = (state_n == ACTIVE && phase_n) ? ~color_n : 3'b111;
  end

  // State, latched grant context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      color_q   <= '0;
      blink_q   <= 1'b0;
      phase_on  <= 1'b1;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      led_q     <= 3'b111;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      color_q   <= color_n;
      blink_q   <= blink_n;
      phase_on  <= phase_n;
      hold_cnt  <= hold_n;
      blink_cnt <= blink_cnt_n;
      led_q     <= led_n;
    end
  end

  assign bus.grant = grant_q;
  assign bus.LED_R = led_q[2];
  assign bus.LED_G = led_q[1];
  assign bus.LED_B = led_q[0];

endmodule

// File: tb/tb_led_status_sched.sv
// Self-checking bench for led_status_sched: directed scenarios plus random
// request traffic, compared every cycle against a behavioural model.
module tb_led_status_sched;

  localparam int DIV   = 2;  // CLK_HZ / TICK_HZ
  localparam int MINH  = 3;
  localparam int BLINK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_status_sched_if bus ();

  led_status_sched #(
    .CLK_HZ(10),
    .TICK_HZ(5),
    .MIN_HOLD_TICKS(MINH),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 dark/idle, 1 showing an owner, 2 dark gap between owners.
  int         k;          // edges since reset; a tick occurs when k % DIV == DIV-1
  int         m_state;
  int         m_own;      // owner index 0..2
  int         m_shown;    // ticks elapsed since grant (unbounded)
  logic [2:0] m_col;
  bit         m_blk;
  bit         m_tick;
  bit         m_met, m_ov, m_hi, m_leave;
  int         m_low;

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic m_grant(input logic [2:0] v, input logic [8:0] c, input logic [2:0] b);
    m_own   = lowest(v);
    m_col   = c[3*m_own +: 3];
    m_blk   = b[m_own];
    m_shown = 0;
    m_state = 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_state = 0; m_own = 0; m_shown = 0; m_col = '0; m_blk = 0;
    end else begin
      m_tick = (k % DIV) == DIV - 1;
      k++;
      case (m_state)
        0: if (bus.req_valid != 0) m_grant(bus.req_valid, bus.req_color, bus.req_blink);
        1: begin
          m_met = m_shown >= MINH;
          m_ov  = bus.req_valid[m_own];
          m_low = lowest(bus.req_valid);
          m_hi  = (m_low >= 0) && (m_low < m_own);
`ifdef LED_STATUS_SCHED_PREEMPT_EN
          m_leave = m_hi || (m_met && !m_ov);
`else
          m_leave = m_met && (m_hi || !m_ov);
`endif
          if (m_leave) m_state = (bus.req_valid != 0) ? 2 : 0;
          else if (m_tick) m_shown++;
        end
        default: if (m_tick) begin
          if (bus.req_valid != 0) m_grant(bus.req_valid, bus.req_color, bus.req_blink);
          else m_state = 0;
        end
      endcase
    end
  end

  function automatic logic [2:0] exp_grant();
    return (m_state == 1) ? 3'(1 << m_own) : 3'b000;
  endfunction

  function automatic logic [2:0] exp_leds();
    bit on;
    on = !m_blk || ((m_shown / BLINK) % 2 == 0);
    return (m_state == 1 && on) ? ~m_col : 3'b111;
  endfunction

  wire [2:0] leds = {bus.LED_R, bus.LED_G, bus.LED_B};

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("grant", 32'(bus.grant), 32'(exp_grant()));
    check("leds", 32'(leds), 32'(exp_leds()));
  end

  // Bounded wait for a grant value; an expired bound shows up as a failed check.
  task automatic wait_grant(input string name, input logic [2:0] g, input int max_cyc);
    for (int i = 0; i < max_cyc && bus.grant !== g; i++) @(negedge clk);
    check(name, 32'(bus.grant), 32'(g));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_color = '0;
    bus.req_blink = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_leds", 32'(leds), 32'h7);

    // Green solid on requester 1
    bus.req_valid = 3'b010;
    bus.req_color = 9'b000_010_000;
    @(negedge clk);
    check("green_grant", 32'(bus.grant), 32'h2);
    check("green_leds", 32'(leds), 32'h5);
    repeat (8) @(negedge clk);
    check("green_steady", 32'(leds), 32'h5);

    // Asynchronous reset mid-grant
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_grant", 32'(bus.grant), 32'h0);
    check("arst_leds", 32'(leds), 32'h7);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Blue blink on requester 2, then requester 0 arrives
    bus.req_valid = 3'b100;
    bus.req_color = 9'b001_000_000;
    bus.req_blink = 3'b100;
    wait_grant("blue_grant", 3'b100, 4);
    check("blue_on_at_grant", 32'(bus.LED_B), 32'h0);
    repeat (16) @(negedge clk);
    bus.req_valid = 3'b101;
    bus.req_color = 9'b001_000_100;
    bus.req_blink = 3'b000;
    wait_grant("preempt_grant", 3'b001, 30);
    check("red_leds", 32'(leds), 32'h3);
    bus.req_valid = 3'b000;
    wait_grant("release_idle", 3'b000, 30);
    repeat (4) @(negedge clk);

    // Owner drops early while its colour input changes
    bus.req_valid = 3'b010;
    bus.req_color = 9'b000_011_000;
    wait_grant("drop_grant", 3'b010, 4);
    repeat (2) @(negedge clk);
    bus.req_valid = 3'b000;
    bus.req_color = 9'b000_110_000;
    @(negedge clk);
    check("latched_color", 32'(leds), 32'h4);
    wait_grant("drop_idle", 3'b000, 20);
    check("drop_dark", 32'(leds), 32'h7);
    repeat (4) @(negedge clk);

    // All three request from idle
    bus.req_valid = 3'b111;
    bus.req_color = 9'b001_010_100;
    @(negedge clk);
    check("all_grant0", 32'(bus.grant), 32'h1);
    repeat (10) @(negedge clk);
    bus.req_valid = 3'b110;
    wait_grant("gap_before_1", 3'b000, 20);
    wait_grant("all_grant1", 3'b010, 20);
    repeat (10) @(negedge clk);
    bus.req_valid = 3'b100;
    wait_grant("gap_before_2", 3'b000, 20);
    wait_grant("all_grant2", 3'b100, 20);
    bus.req_valid = 3'b000;
    repeat (12) @(negedge clk);

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      bus.req_valid = 3'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req_valid = '0;
      bus.req_color = 9'($urandom);
      bus.req_blink = 3'($urandom);
      if (it == 120) begin
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
